// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one combinational-read data-memory port between the
// pipeline MEM stage (port 0) and the loader/debug master (port 1).
// Accesses are serialised, each one drives the memory for ACCESS_LAT cycles
// and completes with a one-cycle ack. Contention is resolved round-robin.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_IDLE    | no access in flight; grant a pending request if any
//   ST_ACCESS  | memory port driven for the latched request, cnt counts down
//   ST_RESP    | ack pulse to the granted port, round-robin pointer flips
module dmem_arbiter #(
  parameter int unsigned ACCESS_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_ack,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_ack,
  output logic [31:0] p1_rdata,
  output logic        stall,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Count loaded at grant; the access ends on the edge where cnt reaches 0.
  localparam logic [3:0] CNT_INIT = 4'(ACCESS_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        p0_ack_q, p0_ack_d;
  logic        p1_ack_q, p1_ack_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Pick the requester to grant: the sole one, or the one prio names on a tie.
  always_comb begin
    sel       = (p0_req & p1_req) ? prio_q : p1_req;
    sel_we    = sel ? p1_we    : p0_we;
    sel_addr  = sel ? p1_addr  : p0_addr;
    sel_wdata = sel ? p1_wdata : p0_wdata;
  end

  // Next-state logic. Memory strobes and acks are computed one cycle ahead so
  // that every output leaves a flop and reset clears them immediately.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;

    case (state_q)
      ST_IDLE: begin
        if (p0_req | p1_req) begin
          state_d     = ST_ACCESS;
          cnt_d       = CNT_INIT;
          gnt_d       = sel;
          we_d        = sel_we;
          addr_d      = sel_addr;
          wdata_d     = sel_wdata;
          mem_addr_d  = sel_addr;
          mem_wdata_d = sel_we ? sel_wdata : 32'd0;
          mem_rd_d    = ~sel_we;
          // With a single-cycle access the write strobe is the first cycle.
          mem_wr_d    = sel_we & (CNT_INIT == 4'd0);
        end
      end

      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (gnt_q) p1_rdata_d = mem_rdata;
            else       p0_rdata_d = mem_rdata;
          end
          p0_ack_d = ~gnt_q;
          p1_ack_d = gnt_q;
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_addr_d  = addr_q;
          mem_wdata_d = we_q ? wdata_q : 32'd0;
          mem_rd_d    = ~we_q;
          // One write strobe per access, in the final ACCESS cycle.
          mem_wr_d    = we_q & (cnt_d == 4'd0);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        prio_d  = ~prio_q;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; async reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      p0_rdata_q  <= 32'd0;
      p1_rdata_q  <= 32'd0;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p0_ack    = p0_ack_q;
  assign p1_ack    = p1_ack_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Pipeline freeze drops in the ack cycle so the MEM stage advances then.
  assign stall = p0_req & ~p0_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a default-latency instance (ACCESS_LAT=2)
// and a single-cycle instance (ACCESS_LAT=1), each with its own small memory.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_ack, p1_ack, stall, mem_rd, mem_wr;
  logic [31:0] p0_rdata, p1_rdata, mem_addr, mem_wdata, mem_rdata;

  logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
  logic [31:0] b_p0_addr, b_p0_wdata, b_p1_addr, b_p1_wdata;
  logic        b_p0_ack, b_p1_ack, b_stall, b_mem_rd, b_mem_wr;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];

  int n_assert = 0;
  int n_fail   = 0;
  logic seen;

  dmem_arbiter #(.ACCESS_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .stall(stall), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ACCESS_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .stall(b_stall), .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read memories with synchronous write.
  assign mem_rdata   = mem_a[mem_addr[3:0]];
  assign b_mem_rdata = mem_b[b_mem_addr[3:0]];

  always @(posedge clk) begin
    if (mem_wr) mem_a[mem_addr[3:0]] <= mem_wdata;
    if (b_mem_wr) mem_b[b_mem_addr[3:0]] <= b_mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One cycle: inputs are driven just after the rising edge, checks follow settle().
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'd0;
      mem_b[i] = 32'd0;
    end
    mem_a[8]  = 32'h0000002A;
    mem_a[12] = 32'h0000000D;
    mem_b[8]  = 32'h0000002A;
    mem_b[12] = 32'h0000000D;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = 0; b_p0_wdata = 0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = 0; b_p1_wdata = 0;
    idle_inputs();
    rst_n = 1'b0;

    // 1. Random inputs under reset: everything quiet, stall mirrors p0_req.
    for (int c = 0; c < 4; c++) begin
      step();
      p0_req = 1'($urandom); p0_we = 1'($urandom); p0_addr = $urandom; p0_wdata = $urandom;
      p1_req = 1'($urandom); p1_we = 1'($urandom); p1_addr = $urandom; p1_wdata = $urandom;
      settle();
      chk("rst_p0_ack", {31'd0, p0_ack}, 32'd0);
      chk("rst_p1_ack", {31'd0, p1_ack}, 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_p1_rdata", p1_rdata, 32'd0);
      chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_stall", {31'd0, stall}, {31'd0, p0_req});
    end
    // Release with both requesting: port 0 wins the first grant.
    step();
    rst_n = 1'b1;
    p0_req = 1; p0_we = 0; p0_addr = 32'd8;
    p1_req = 1; p1_we = 0; p1_addr = 32'd12;
    settle();
    chk("first_stall", {31'd0, stall}, 32'd1);
    step(); settle();
    chk("first_grant_addr", mem_addr, 32'd8);
    chk("first_grant_rd", {31'd0, mem_rd}, 32'd1);
    do_reset();

    // 2. Port 0 read of word 8.
    for (int c = 0; c <= 4; c++) begin
      step();
      if (c == 0) begin p0_req = 1; p0_we = 0; p0_addr = 32'd8; end
      settle();
      chk("t2_mem_rd", {31'd0, mem_rd}, (c == 1 || c == 2) ? 32'd1 : 32'd0);
      chk("t2_mem_addr", mem_addr, (c == 1 || c == 2) ? 32'd8 : 32'd0);
      chk("t2_ack", {31'd0, p0_ack}, (c == 3) ? 32'd1 : 32'd0);
      chk("t2_stall", {31'd0, stall}, (c <= 2) ? 32'd1 : 32'd0);
      if (c == 3) begin
        chk("t2_rdata", p0_rdata, 32'h0000002A);
        p0_req = 0;
      end
    end

    // 3. Port 1 write of 0xDEADBEEF to word 12, then a port 0 read-back.
    for (int c = 0; c <= 4; c++) begin
      step();
      if (c == 0) begin p1_req = 1; p1_we = 1; p1_addr = 32'd12; p1_wdata = 32'hDEADBEEF; end
      settle();
      chk("t3_mem_wr", {31'd0, mem_wr}, (c == 2) ? 32'd1 : 32'd0);
      if (c == 2) chk("t3_mem_wdata", mem_wdata, 32'hDEADBEEF);
      chk("t3_p1_ack", {31'd0, p1_ack}, (c == 3) ? 32'd1 : 32'd0);
      if (c == 3) begin
        chk("t3_p1_rdata_kept", p1_rdata, 32'd0);
        p1_req = 0; p1_we = 0;
      end
    end
    p0_req = 1; p0_we = 0; p0_addr = 32'd12;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(); settle();
      if (p0_ack) seen = 1;
    end
    chk("t3_readback_ack", {31'd0, seen}, 32'd1);
    chk("t3_readback_data", p0_rdata, 32'hDEADBEEF);
    p0_req = 0;

    // 4. Both ports reading continuously: strict alternation starting with p0.
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      step();
      if (c == 0) begin
        p0_req = 1; p0_we = 0; p0_addr = 32'd8;
        p1_req = 1; p1_we = 0; p1_addr = 32'd12;
      end
      settle();
      chk("t4_p0_ack", {31'd0, p0_ack}, (c == 3 || c == 11) ? 32'd1 : 32'd0);
      chk("t4_p1_ack", {31'd0, p1_ack}, (c == 7) ? 32'd1 : 32'd0);
      if (c == 3) chk("t4_p0_rdata", p0_rdata, 32'h0000002A);
      if (c == 7) chk("t4_p1_rdata", p1_rdata, 32'hDEADBEEF);
    end

    // 5. Reset during a write access: no strobe, no ack, memory untouched.
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      step();
      if (c == 0) begin p1_req = 1; p1_we = 1; p1_addr = 32'd8; p1_wdata = 32'h12345678; end
      if (c == 1) begin rst_n = 1'b0; p1_req = 0; p1_we = 0; end
      if (c == 2) rst_n = 1'b1;
      settle();
      chk("t5_mem_wr", {31'd0, mem_wr}, 32'd0);
      chk("t5_p1_ack", {31'd0, p1_ack}, 32'd0);
      if (c == 1) chk("t5_mem_addr_cleared", mem_addr, 32'd0);
    end
    p0_req = 1; p0_we = 0; p0_addr = 32'd8;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step(); settle();
      if (p0_ack) seen = 1;
    end
    chk("t5_readback_ack", {31'd0, seen}, 32'd1);
    chk("t5_readback_data", p0_rdata, 32'h0000002A);
    p0_req = 0;

    // 6. Single-cycle access instance: port 0 read of word 12.
    for (int c = 0; c <= 3; c++) begin
      step();
      if (c == 0) begin b_p0_req = 1; b_p0_we = 0; b_p0_addr = 32'd12; end
      settle();
      chk("t6_mem_rd", {31'd0, b_mem_rd}, (c == 1) ? 32'd1 : 32'd0);
      if (c == 1) chk("t6_mem_addr", b_mem_addr, 32'd12);
      chk("t6_ack", {31'd0, b_p0_ack}, (c == 2) ? 32'd1 : 32'd0);
      if (c == 2) begin
        chk("t6_rdata", b_p0_rdata, 32'h0000000D);
        b_p0_req = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Shares the single data-memory port (read enable, write enable, word address, write data, combinational read data) between two requesters.
  - Port 0: the pipeline MEM stage.
  - Port 1: the loader/debug master.
- Serialises accesses and models a configurable access latency.
- Returns read data with a one-cycle acknowledge pulse.
- Provides the stall signal that freezes the pipeline while a MEM-stage access is outstanding.

## Interface
Parameters:
- ACCESS_LAT, 2, cycles the memory port is driven per access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- p0_req  in  1  MEM-stage request; held high until p0_ack.
- p0_we  in  1  1 = write, 0 = read.
- p0_addr  in  32  word address.
- p0_wdata  in  32  write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  32  read data; valid when p0_ack is high, held until port 0's next read completes.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for the loader port.
- stall  out  1  pipeline freeze: p0_req & ~p0_ack, combinational.
- mem_rd  out  1  memory read enable.
- mem_wr  out  1  memory write enable.
- mem_addr  out  32  memory address; the 32-bit address of the latched request, passed through unchanged.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; combinational from mem_addr.

## Operation
- **FSM states:** IDLE, ACCESS, RESP. A 4-bit down-counter `cnt` and a 1-bit round-robin pointer `prio` (0 = port 0 preferred).
- **IDLE**
  - If any req is high, grant: the sole requester, or the requester `prio` names when both are high.
  - Latch that port's we/addr/wdata into internal registers.
  - Set `cnt` = ACCESS_LAT-1 and go to ACCESS. Otherwise stay in IDLE.
- **ACCESS**
  - mem_addr = latched addr.
  - mem_wdata = latched wdata when latched we = 1, else 0.
  - For a read, mem_rd = 1 for every ACCESS cycle.
  - For a write, mem_wr = 1 only when `cnt` == 0, so exactly one write strobe per access.
  - `cnt` decrements each cycle. On the edge where `cnt` == 0:
    - for a read, capture mem_rdata into the granted port's rdata register;
    - go to RESP.
- **RESP**
  - The granted port's ack = 1 for this one cycle.
  - `prio` toggles to the other port.
  - Next state is always IDLE.
- **Outside ACCESS:** mem_rd, mem_wr, mem_addr and mem_wdata are all 0.
- **Protocol:**
  - Request fields are sampled only at grant; changes after grant are ignored.
  - A requester that drops req after grant still receives its ack; the access is never cancelled except by reset.
  - req still high in the IDLE cycle after ack is treated as a new request.
- **Write ack:** p*_rdata is unchanged on a write ack.

## Timing
- Reset values (rst_n low, asynchronous): state = IDLE, `cnt` = 0, `prio` = 0, p0_rdata = p1_rdata = 0, both acks 0, all mem_* outputs 0. stall follows p0_req.
- Latency: req high in IDLE cycle N → ACCESS cycles N+1..N+ACCESS_LAT → ack in cycle N+ACCESS_LAT+1.
- Throughput: one access per ACCESS_LAT+2 cycles.
- With ACCESS_LAT = 1, ACCESS lasts one cycle and mem_rd or mem_wr is high that single cycle.
- Simultaneous requests alternate strictly while both stay asserted: p0, p1, p0, …
- Reset during ACCESS: outputs drop to 0 immediately and no ack is issued.
  - A write whose `cnt` had not reached 0 is never strobed, so memory is unchanged.
  - A completed write is not undone.
- Reset during RESP: the ack pulse is truncated.

## Test plan
ACCESS_LAT = 2 unless stated; memory model preloaded with word 8 = 0x0000002A and word 12 = 0x0000000D.
1. rst_n low with random inputs, then release → all outputs 0, with stall = p0_req; first grant goes to p0 when both request.
2. p0 read addr 8 raised in cycle 0 →
   - mem_rd = 1 and mem_addr = 8 in cycles 1–2;
   - p0_ack in cycle 3 with p0_rdata = 0x0000002A;
   - stall high in cycles 0–2 and low in cycle 3.
3. p1 write addr 12, wdata 0xDEADBEEF →
   - mem_wr high in exactly one cycle (cycle 2), with mem_wdata = 0xDEADBEEF;
   - p1_ack in cycle 3;
   - a following p0 read of 12 returns 0xDEADBEEF.
4. p0 and p1 both requesting reads continuously from cycle 0 → acks in cycle 3 (p0), cycle 7 (p1), cycle 11 (p0); each ack is one cycle wide.
5. p1 write 0x12345678 to addr 8, with rst_n pulsed low in cycle 1 → mem_wr never high, no ack; a subsequent p0 read of 8 returns 0x0000002A.
6. ACCESS_LAT = 1: p0 read addr 12 in cycle 0 → mem_rd high only in cycle 1; p0_ack in cycle 2 with p0_rdata = 0x0000000D.
